// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with pipelined sync/blank alignment.
//
// Ports:
//   clock             pixel clock
//   reset             asynchronous, active-high reset
//   R_in/G_in/B_in    pixel colour from the renderers, valid PIPE-1 clocks after x,y
//   x, y              current pixel coordinate (straight from the counter registers)
//   video_on          (x,y) inside the visible area, aligned with x,y
//   frame_tick        one-clock pulse at (0,0), aligned with x,y
//   hsync, vsync      active-low syncs, delayed PIPE clocks relative to x,y
//   blank_n           active-low DAC blanking, delayed PIPE clocks relative to x,y
//   sync_n            composite sync, held high
//   R, G, B           registered colour to the DAC, zero outside the visible area
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned PIPE      = 2   // legal range 1..4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] R_in,
   input  logic [9:0] G_in,
   input  logic [9:0] B_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       frame_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic [9:0] R,
   output logic [9:0] G,
   output logic [9:0] B
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0]      h_q, h_d;
   logic [9:0]      v_q, v_d;
   logic            hs_raw, vs_raw;
   logic [PIPE-1:0] hs_pipe_q, hs_pipe_d;
   logic [PIPE-1:0] vs_pipe_q, vs_pipe_d;
   logic [PIPE-1:0] vid_pipe_q, vid_pipe_d;
   logic            vid_gate;
   logic [9:0]      r_q, g_q, b_q;
   logic [9:0]      r_d, g_d, b_d;

   // Raster counters: v advances only on the clock where h wraps.
   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_MAX) begin
         h_d = '0;
         v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
      end
   end

   always_comb begin
      video_on   = (h_q < H_VIS) && (v_q < V_VIS);
      frame_tick = (h_q == '0) && (v_q == '0);
      hs_raw     = !((h_q >= H_SYNC_BEG) && (h_q <= H_SYNC_END));
      vs_raw     = !((v_q >= V_SYNC_BEG) && (v_q <= V_SYNC_END));
   end

   // Alignment shift registers: stage 0 takes the raw value, the last stage drives the pins.
   always_comb begin
      hs_pipe_d     = hs_pipe_q;
      vs_pipe_d     = vs_pipe_q;
      vid_pipe_d    = vid_pipe_q;
      hs_pipe_d[0]  = hs_raw;
      vs_pipe_d[0]  = vs_raw;
      vid_pipe_d[0] = video_on;
      for (int i = PIPE - 1; i > 0; i--) begin
         hs_pipe_d[i]  = hs_pipe_q[i-1];
         vs_pipe_d[i]  = vs_pipe_q[i-1];
         vid_pipe_d[i] = vid_pipe_q[i-1];
      end
   end

   // Colour arrives PIPE-1 clocks after its coordinate, so it is gated by video_on
   // delayed by the same amount; the colour register adds the final clock.
   if (PIPE == 1) begin : g_gate_direct
      assign vid_gate = video_on;
   end else begin : g_gate_piped
      assign vid_gate = vid_pipe_q[PIPE-2];
   end

   always_comb begin
      r_d = vid_gate ? R_in : '0;
      g_d = vid_gate ? G_in : '0;
      b_d = vid_gate ? B_in : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_q        <= '0;
         v_q        <= '0;
         hs_pipe_q  <= '1;
         vs_pipe_q  <= '1;
         vid_pipe_q <= '0;
         r_q        <= '0;
         g_q        <= '0;
         b_q        <= '0;
      end else begin
         h_q        <= h_d;
         v_q        <= v_d;
         hs_pipe_q  <= hs_pipe_d;
         vs_pipe_q  <= vs_pipe_d;
         vid_pipe_q <= vid_pipe_d;
         r_q        <= r_d;
         g_q        <= g_d;
         b_q        <= b_d;
      end
   end

   assign x       = h_q;
   assign y       = v_q;
   assign hsync   = hs_pipe_q[PIPE-1];
   assign vsync   = vs_pipe_q[PIPE-1];
   assign blank_n = vid_pipe_q[PIPE-1];
   assign sync_n  = 1'b1;
   assign R       = r_q;
   assign G       = g_q;
   assign B       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. Two instances (PIPE=2 and PIPE=1)
// with a reduced raster share randomized colour stimulus; expectations come from an
// arithmetic model of the raster (coordinate = cycle count mod totals).
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int HV = 40, HF = 6, HS = 10, HB = 8;
   localparam int VV = 12, VF = 3, VS = 2, VB = 4;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int MAXC = 8192;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] rin = '0, gin = '0, bin = '0;

   logic [9:0] a_x, a_y, a_r, a_g, a_b;
   logic       a_von, a_ft, a_hs, a_vs, a_bn, a_sn;
   logic [9:0] b_x, b_y, b_r, b_g, b_b;
   logic       b_von, b_ft, b_hs, b_vs, b_bn, b_sn;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE(2)
   ) u_dut_p2 (
      .clock(clk), .reset(rst), .R_in(rin), .G_in(gin), .B_in(bin),
      .x(a_x), .y(a_y), .video_on(a_von), .frame_tick(a_ft), .hsync(a_hs), .vsync(a_vs),
      .blank_n(a_bn), .sync_n(a_sn), .R(a_r), .G(a_g), .B(a_b)
   );

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .PIPE(1)
   ) u_dut_p1 (
      .clock(clk), .reset(rst), .R_in(rin), .G_in(gin), .B_in(bin),
      .x(b_x), .y(b_y), .video_on(b_von), .frame_tick(b_ft), .hsync(b_hs), .vsync(b_vs),
      .blank_n(b_bn), .sync_n(b_sn), .R(b_r), .G(b_g), .B(b_b)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       von;
      logic       ft;
      logic       hs;
      logic       vs;
      logic       bn;
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
      logic       rom_chk;
      logic [9:0] rom_r;
   } exp_t;

   exp_t       qa[$];
   exp_t       qb[$];
   logic [29:0] hist [0:MAXC-1];
   logic        romh [0:MAXC-1];
   int          c = 0;
   int          mode = 0;  // 0 random colour, 1 ROM of x, 2 constant 3FF red
   int          n_checks = 0;
   int          n_fail = 0;
   int          hlow = 0;
   bit          hvalid = 0;

   function automatic logic [9:0] rom(int xx);
      return 10'((xx * 37 + 5) % 1024);
   endfunction

   // Expected outputs at cycle cc after reset release (cc = number of clock edges since).
   function automatic exp_t model(int cc, int p, bit in_rst);
      exp_t e;
      int   d, dx, dy, xi, yi;
      e = '{x: '0, y: '0, von: 1'b1, ft: 1'b1, hs: 1'b1, vs: 1'b1, bn: 1'b0,
            r: '0, g: '0, b: '0, rom_chk: 1'b0, rom_r: '0};
      if (in_rst) return e;
      xi    = cc % HT;
      yi    = (cc / HT) % VT;
      e.x   = 10'(xi);
      e.y   = 10'(yi);
      e.von = (xi < HV) && (yi < VV);
      e.ft  = (xi == 0) && (yi == 0);
      d = cc - p;
      if (d >= 0) begin
         dx   = d % HT;
         dy   = (d / HT) % VT;
         e.hs = !((dx >= HV + HF) && (dx < HV + HF + HS));
         e.vs = !((dy >= VV + VF) && (dy < VV + VF + VS));
         e.bn = (dx < HV) && (dy < VV);
         if (e.bn) {e.r, e.g, e.b} = hist[cc-1];
         if (e.bn && romh[cc-1] && p == 2) begin
            e.rom_chk = 1'b1;
            e.rom_r   = rom(dx);
         end
      end
      return e;
   endfunction

   task automatic chk10(string nm, logic [9:0] act, logic [9:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic chk1(string nm, logic act, logic expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic drive();
      if (mode == 2)      rin = 10'h3FF;
      else if (mode == 1) rin = rom((c - 1 + HT) % HT);  // one-clock ROM latency
      else                rin = 10'($urandom_range(0, 1023));
      gin = 10'($urandom);
      bin = 10'($urandom);
      if (!rst) begin
         hist[c] = {rin, gin, bin};
         romh[c] = (mode == 1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!rst) c++;
      if (c >= MAXC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", c, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      drive();
      qa.push_back(model(c, 2, rst));
      qb.push_back(model(c, 1, rst));
   endtask

   task automatic release_rst();
      rst = 1'b0;
      c   = 0;
      hist[0] = {rin, gin, bin};
      romh[0] = (mode == 1);
   endtask

   // Monitor: every clock both instances present a full output set.
   always @(negedge clk) begin
      exp_t ea, eb;
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         chk10("p2.x", a_x, ea.x);
         chk10("p2.y", a_y, ea.y);
         chk1("p2.video_on", a_von, ea.von);
         chk1("p2.frame_tick", a_ft, ea.ft);
         chk1("p2.hsync", a_hs, ea.hs);
         chk1("p2.vsync", a_vs, ea.vs);
         chk1("p2.blank_n", a_bn, ea.bn);
         chk1("p2.sync_n", a_sn, 1'b1);
         chk10("p2.R", a_r, ea.r);
         chk10("p2.G", a_g, ea.g);
         chk10("p2.B", a_b, ea.b);
         if (ea.rom_chk) chk10("p2.R_rom_alignment", a_r, ea.rom_r);
      end
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         chk10("p1.x", b_x, eb.x);
         chk10("p1.y", b_y, eb.y);
         chk1("p1.video_on", b_von, eb.von);
         chk1("p1.frame_tick", b_ft, eb.ft);
         chk1("p1.hsync", b_hs, eb.hs);
         chk1("p1.vsync", b_vs, eb.vs);
         chk1("p1.blank_n", b_bn, eb.bn);
         chk1("p1.sync_n", b_sn, 1'b1);
         chk10("p1.R", b_r, eb.r);
         chk10("p1.G", b_g, eb.g);
         chk10("p1.B", b_b, eb.b);
      end
      // Every complete hsync pulse must be exactly HS clocks wide.
      if (rst) begin
         hlow   = 0;
         hvalid = 0;
      end else if (!a_hs) begin
         hlow++;
      end else begin
         if (hvalid && hlow != 0) chk10("p2.hsync_width", 10'(hlow), 10'(HS));
         hlow   = 0;
         hvalid = 1;
      end
   end

   initial begin
      int target, steps;
      rst  = 1'b1;
      mode = 0;
      drive();
      repeat (3) step();
      release_rst();

      repeat (FRAME + HT) step();        // random colour, beyond one frame wrap
      mode = 2;
      repeat (FRAME) step();             // constant full-scale red
      mode = 1;
      repeat (FRAME) step();             // ROM-latency colour source

      // Advance to a point inside both the hsync and vsync pulses, then reset mid-frame.
      mode   = 0;
      target = (VV + VF) * HT + (HV + HF + 2);
      steps  = ((target - (c % FRAME)) + FRAME) % FRAME;
      if (steps < 4) steps += FRAME;
      repeat (steps) step();
      #5;
      chk1("pre_reset.hsync_low", a_hs, 1'b0);
      chk1("pre_reset.vsync_low", a_vs, 1'b0);
      rst = 1'b1;
      #1;
      chk10("async_reset.x", a_x, 10'd0);
      chk10("async_reset.y", a_y, 10'd0);
      chk1("async_reset.hsync", a_hs, 1'b1);
      chk1("async_reset.vsync", a_vs, 1'b1);
      chk1("async_reset.blank_n", a_bn, 1'b0);
      chk10("async_reset.R", a_r, 10'd0);
      chk1("async_reset.p1_hsync", b_hs, 1'b1);
      chk10("async_reset.p1_R", b_r, 10'd0);
      repeat (2) step();
      release_rst();

      repeat (FRAME + HT) step();
      repeat (2) @(negedge clk);
      #1;
      chk10("scoreboard_drained_p2", 10'(qa.size()), 10'd0);
      chk10("scoreboard_drained_p1", 10'(qb.size()), 10'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, the vertical equivalents in lines.
REQ-006 SHALL have parameter PIPE, default 2, range 1-4, the sync/blank alignment delay in clocks.
REQ-007 SHALL have port clock, input, 1, pixel clock (25 MHz nominal).
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have ports R_in, G_in, B_in, input, 10 each, pixel colour from the renderers.
REQ-010 SHALL have ports x, y, output, 10 each, current pixel coordinate.
REQ-011 SHALL have port video_on, output, 1, high when (x,y) is inside the visible area.
REQ-012 SHALL have port frame_tick, output, 1, one-clock pulse at the start of each frame.
REQ-013 SHALL have ports hsync, vsync, output, 1 each, active-low sync to the monitor.
REQ-014 SHALL have ports blank_n, sync_n, output, 1 each, DAC blanking (active low) and composite sync (held 1).
REQ-015 SHALL have ports R, G, B, output, 10 each, registered colour to the DAC.

Function
REQ-016 SHALL keep h_count 0 to H_TOTAL-1, where H_TOTAL = sum of the four H parameters (800), incrementing every clock and wrapping to 0.
REQ-017 SHALL keep v_count 0 to V_TOTAL-1 (525), incrementing only on the clock where h_count wraps, and wrapping to 0 when both counters are at their maximum.
REQ-018 SHALL drive x = h_count and y = v_count straight from the counter registers, with zero combinational logic.
REQ-019 SHALL drive video_on = (h_count < H_VISIBLE) && (v_count < V_VISIBLE), undelayed and aligned with x,y.
REQ-020 SHALL assert frame_tick for exactly one clock, when h_count==0 and v_count==0, aligned with x,y.
REQ-021 SHALL define raw hsync low for h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751].
REQ-022 SHALL define raw vsync low for v_count in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], for the full lines.
REQ-023 SHALL delay raw hsync, vsync and video_on by a PIPE-stage shift register before output; blank_n = delayed video_on.
REQ-024 SHALL treat R_in/G_in/B_in as valid PIPE-1 clocks after the x,y they correspond to (1 clock for a sprite ROM read).
REQ-025 SHALL register R,G,B from R_in/G_in/B_in each clock, forcing 0 when video_on delayed PIPE-1 stages is low.
REQ-026 SHALL therefore present hsync, vsync, blank_n and R,G,B for coordinate (x,y) exactly PIPE clocks after x,y show it.
REQ-027 SHALL hold sync_n at constant 1.

Reset
REQ-028 SHALL, while reset=1, asynchronously force h_count=0, v_count=0, hsync=1, vsync=1, blank_n=0, R=G=B=0, and every delay stage to the inactive value (sync 1, video 0).
REQ-029 SHALL output frame_tick=1 and video_on=1 during reset, because they decode x=y=0 combinationally.
REQ-030 SHALL, on the first rising edge after reset deasserts, advance h_count to 1; a mid-frame reset restarts the frame with no partial sync pulse.

Verification
REQ-031 SHALL cover: release reset, run 800 clocks -> x counts 0..799 and wraps to 0; y goes 0->1 on that wrap.
REQ-032 SHALL cover: run 1 full frame (420000 clocks) -> exactly one frame_tick per 420000 clocks; 2 vsync-low lines (490,491); 525 hsync pulses, each 96 clocks wide.
REQ-033 SHALL cover: R_in = 10'h3FF constant -> R=0 whenever blank_n=0; R=3FF on all 640x480 visible pixels; hsync falls PIPE clocks after x=656.
REQ-034 SHALL cover: R_in driven as a 1-clock-delayed function of x (model ROM) -> R at delayed pixel 0 equals the value for x=0, i.e. no 1-pixel shift, checked for PIPE=2.
REQ-035 SHALL cover: reset asserted at x=700, y=300 -> within the same clock x=y=0, hsync=vsync=1, R=0; after release, counting resumes from 0.
REQ-036 SHALL cover: PIPE=1 build -> sync edges coincide with counter edges shifted one clock; R registered from R_in of the same coordinate.
